udsweep_ctrl: RTL and testbench

UDSWEEP_CTRL -- requirements
Module: udsweep_ctrl

---
 rtl/udsweep_pkg.sv | 14 +
 rtl/udsweep_ctrl_if.sv | 34 +++
 rtl/udcnt_core.sv | 39 +++
 rtl/udsweep_ctrl.sv | 152 +++++++++++++++
 tb/tb_udsweep_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/udsweep_pkg.sv
// Shared types and default widths for the up/down sweep controller.
// No logic; imported by the controller, its interface and the counter core.
package udsweep_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CYC_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } state_t;

endpackage

// File: rtl/udsweep_ctrl_if.sv
// Control and status bundle of the sweep controller; master issues commands, slave is the controller.
// Plain wires, no storage: latency and backpressure are those of the controller itself.
interface udsweep_ctrl_if
   import udsweep_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CYC_W = DEF_CYC_W
) ();

   logic             start;
   logic             abort;
   logic             pause;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;
   logic [CYC_W-1:0] cycles;

   logic [WIDTH-1:0] count;
   logic             dir;
   logic             busy;
   logic             done;
   logic             err;
   logic [CYC_W-1:0] cyc_left;

   modport master (
      output start, abort, pause, lo, hi, cycles,
      input  count, dir, busy, done, err, cyc_left
   );

   modport slave (
      input  start, abort, pause, lo, hi, cycles,
      output count, dir, busy, done, err, cyc_left
   );

endinterface

// File: rtl/udcnt_core.sv
// WIDTH-bit up/down counter with load; load beats enable, mode 1 counts up.
// One-cycle latency from load/en to count; no backpressure, steps whenever enabled.
module udcnt_core
   import udsweep_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             mode,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en) begin
         count_d = mode ? count_q + 1'b1 : count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/udsweep_ctrl.sv
// Sweeps a counter lo->hi->lo a programmed number of times; pause freezes, abort returns to IDLE.
// All outputs registered, one cycle after the causing input; start while busy is dropped, not queued.
module udsweep_ctrl
   import udsweep_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CYC_W = DEF_CYC_W
) (
   input  logic           clk,
   input  logic           rst,
   udsweep_ctrl_if.slave  sw
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [CYC_W-1:0] cyc_left_q, cyc_left_d;
   logic             dir_q, dir_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             core_load;
   logic [WIDTH-1:0] core_val;
   logic             core_en;
   logic             core_mode;
   logic [WIDTH-1:0] count;

   udcnt_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (core_load),
      .load_val (core_val),
      .en       (core_en),
      .mode     (core_mode),
      .count    (count)
   );

   always_comb begin
      state_d    = state_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      cyc_left_d = cyc_left_q;
      dir_d      = dir_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      core_load  = 1'b0;
      core_val   = sw.lo;
      core_en    = 1'b0;
      core_mode  = 1'b0;

      case (state_q)
         IDLE: begin
            if (!sw.abort && sw.start) begin
               if (sw.lo >= sw.hi || sw.cycles == '0) begin
                  err_d = 1'b1;
               end else begin
                  core_load  = 1'b1;
                  lo_d       = sw.lo;
                  hi_d       = sw.hi;
                  cyc_left_d = sw.cycles;
                  state_d    = UP;
                  busy_d     = 1'b1;
                  dir_d      = 1'b1;
               end
            end
         end

         UP: begin
            if (sw.abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               dir_d   = 1'b0;
            end else if (!sw.pause) begin
               core_en = 1'b1;
               if (count == hi_q) begin
                  // hi is shown for exactly one cycle before turning down
                  core_mode = 1'b0;
                  state_d   = DOWN;
                  dir_d     = 1'b0;
               end else begin
                  core_mode = 1'b1;
               end
            end
         end

         DOWN: begin
            if (sw.abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               dir_d   = 1'b0;
            end else if (!sw.pause) begin
               if (count != lo_q) begin
                  core_en   = 1'b1;
                  core_mode = 1'b0;
               end else if (cyc_left_q > CYC_W'(1)) begin
                  // turn straight back up so lo is not repeated between sweeps
                  cyc_left_d = cyc_left_q - 1'b1;
                  core_en    = 1'b1;
                  core_mode  = 1'b1;
                  state_d    = UP;
                  dir_d      = 1'b1;
               end else begin
                  cyc_left_d = '0;
                  state_d    = IDLE;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            dir_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         lo_q       <= '0;
         hi_q       <= '0;
         cyc_left_q <= '0;
         dir_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         lo_q       <= lo_d;
         hi_q       <= hi_d;
         cyc_left_q <= cyc_left_d;
         dir_q      <= dir_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign sw.count    = count;
   assign sw.dir      = dir_q;
   assign sw.busy     = busy_q;
   assign sw.done     = done_q;
   assign sw.err      = err_q;
   assign sw.cyc_left = cyc_left_q;

endmodule

// File: tb/tb_udsweep_ctrl.sv
// Self-checking bench for udsweep_ctrl: expected per-cycle outputs queued at stimulus time.
// Outputs sampled and inputs driven on the falling edge.
module tb_udsweep_ctrl;

   typedef struct packed {
      logic [7:0] count;
      logic       dir;
      logic       busy;
      logic       done;
      logic       err;
      logic [3:0] cyc_left;
   } obs_t;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;
   obs_t exp_q[$];
   obs_t o;
   obs_t prev;
   int   bc;

   logic [7:0] p_at_g;
   int         p_len_g;
   bit         paused_g;

   udsweep_ctrl_if #(.WIDTH(8), .CYC_W(4)) sw_if ();

   udsweep_ctrl #(
      .WIDTH (8),
      .CYC_W (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .sw  (sw_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic obs_t sample();
      obs_t s;
      s = '{sw_if.count, sw_if.dir, sw_if.busy, sw_if.done, sw_if.err, sw_if.cyc_left};
      return s;
   endfunction

   function automatic obs_t mk(input logic [7:0] c, input logic d, input logic b,
                               input logic dn, input logic er, input logic [3:0] l);
      obs_t e;
      e = '{c, d, b, dn, er, l};
      return e;
   endfunction

   // pushes one expected cycle, plus the repeats caused by a pause at that value
   task automatic push_e(input obs_t e);
      exp_q.push_back(e);
      if (p_len_g > 0 && !paused_g && e.count == p_at_g) begin
         repeat (p_len_g) exp_q.push_back(e);
         paused_g = 1'b1;
      end
   endtask

   // called at a falling edge with the DUT idle; returns at the falling edge showing done
   task automatic run_sweep(input logic [7:0] l, input logic [7:0] h, input logic [3:0] c,
                            input logic [7:0] p_at, input int p_len, input bit hold_start,
                            output int busy_cycles);
      obs_t e;
      int   step;
      int   pause_cnt;
      bit   pdone;
      p_at_g   = p_at;
      p_len_g  = p_len;
      paused_g = 1'b0;
      exp_q.delete();
      push_e(mk(l, 1'b1, 1'b1, 1'b0, 1'b0, c));
      for (int k = 0; k < int'(c); k++) begin
         for (int v = int'(l) + 1; v <= int'(h); v++)
            push_e(mk(8'(v), 1'b1, 1'b1, 1'b0, 1'b0, 4'(int'(c) - k)));
         for (int v = int'(h) - 1; v >= int'(l); v--)
            push_e(mk(8'(v), 1'b0, 1'b1, 1'b0, 1'b0, 4'(int'(c) - k)));
      end
      exp_q.push_back(mk(l, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0));

      sw_if.lo     = l;
      sw_if.hi     = h;
      sw_if.cycles = c;
      sw_if.start  = 1'b1;
      sw_if.pause  = 1'b0;
      busy_cycles  = 0;
      step         = 0;
      pause_cnt    = 0;
      pdone        = 1'b0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         sw_if.start = hold_start;
         e = exp_q.pop_front();
         o = sample();
         chk($sformatf("sweep %0d-%0d x%0d step %0d", l, h, c, step), 32'(o), 32'(e));
         if (o.busy) busy_cycles++;
         if (pause_cnt > 0) begin
            pause_cnt--;
            if (pause_cnt == 0) sw_if.pause = 1'b0;
         end else if (!pdone && p_len > 0 && e.count == p_at) begin
            sw_if.pause = 1'b1;
            pause_cnt   = p_len;
            pdone       = 1'b1;
         end
         step++;
      end
      sw_if.start = 1'b0;
   endtask

   task automatic wait_for(input logic [7:0] cnt, input logic d, input int budget, input string tag);
      bit found;
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (sw_if.busy && sw_if.count == cnt && sw_if.dir == d) found = 1'b1;
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   task automatic err_case(input logic [7:0] l, input logic [7:0] h, input logic [3:0] c);
      prev = sample();
      sw_if.lo     = l;
      sw_if.hi     = h;
      sw_if.cycles = c;
      sw_if.start  = 1'b1;
      @(negedge clk);
      sw_if.start = 1'b0;
      chk($sformatf("err pulse %0d-%0d x%0d", l, h, c), 32'(sample()),
          32'(mk(prev.count, 1'b0, 1'b0, 1'b0, 1'b1, prev.cyc_left)));
      @(negedge clk);
      chk($sformatf("err clear %0d-%0d x%0d", l, h, c), 32'(sample()),
          32'(mk(prev.count, 1'b0, 1'b0, 1'b0, 1'b0, prev.cyc_left)));
   endtask

   initial begin
      n_chk        = 0;
      n_err        = 0;
      rst          = 1'b0;
      sw_if.start  = 1'b1;
      sw_if.abort  = 1'b1;
      sw_if.pause  = 1'b1;
      sw_if.lo     = 8'd1;
      sw_if.hi     = 8'd3;
      sw_if.cycles = 4'd1;

      repeat (2) begin
         @(negedge clk);
         chk("reset state", 32'(sample()), 32'(mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0)));
      end
      rst         = 1'b1;
      sw_if.start = 1'b0;
      sw_if.abort = 1'b0;
      sw_if.pause = 1'b0;
      @(negedge clk);
      chk("idle after reset", 32'(sample()), 32'(mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0)));

      // single sweep, then a second run started in the done cycle
      run_sweep(8'd2, 8'd4, 4'd1, 8'hff, 0, 1'b0, bc);
      chk("busy cycles 2-4 x1", 32'(bc), 32'd5);
      run_sweep(8'd0, 8'd3, 4'd2, 8'hff, 0, 1'b0, bc);
      chk("busy cycles 0-3 x2", 32'(bc), 32'd13);
      @(negedge clk);
      chk("done is one cycle", 32'(sample()), 32'(mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0)));

      run_sweep(8'd1, 8'd6, 4'd1, 8'd3, 3, 1'b0, bc);
      chk("busy cycles with pause", 32'(bc), 32'd14);

      // start held high throughout a run must be ignored while busy
      run_sweep(8'd1, 8'd3, 4'd2, 8'hff, 0, 1'b1, bc);
      chk("busy cycles start held", 32'(bc), 32'd9);
      @(negedge clk);

      err_case(8'd5, 8'd5, 4'd2);
      err_case(8'd1, 8'd3, 4'd0);
      err_case(8'd6, 8'd2, 4'd1);

      // abort during UP freezes count, no done
      sw_if.lo     = 8'd0;
      sw_if.hi     = 8'd7;
      sw_if.cycles = 4'd1;
      sw_if.start  = 1'b1;
      @(negedge clk);
      sw_if.start = 1'b0;
      wait_for(8'd4, 1'b1, 20, "reach 4 up");
      sw_if.abort = 1'b1;
      @(negedge clk);
      sw_if.abort = 1'b0;
      chk("abort to idle", 32'(sample() >> 4), 32'(mk(8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0) >> 4));
      @(negedge clk);
      chk("abort no done", 32'(sample() >> 4), 32'(mk(8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0) >> 4));

      // abort in IDLE beats a simultaneous valid start
      sw_if.lo     = 8'd1;
      sw_if.hi     = 8'd2;
      sw_if.cycles = 4'd1;
      sw_if.start  = 1'b1;
      sw_if.abort  = 1'b1;
      @(negedge clk);
      sw_if.start = 1'b0;
      sw_if.abort = 1'b0;
      chk("abort beats start", 32'(sample() >> 4), 32'(mk(8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0) >> 4));

      run_sweep(8'd1, 8'd2, 4'd1, 8'hff, 0, 1'b0, bc);
      chk("busy cycles after abort", 32'(bc), 32'd3);
      @(negedge clk);

      // abort has priority over pause
      sw_if.lo     = 8'd0;
      sw_if.hi     = 8'd7;
      sw_if.cycles = 4'd1;
      sw_if.start  = 1'b1;
      @(negedge clk);
      sw_if.start = 1'b0;
      wait_for(8'd2, 1'b1, 20, "reach 2 up");
      sw_if.abort = 1'b1;
      sw_if.pause = 1'b1;
      @(negedge clk);
      sw_if.abort = 1'b0;
      sw_if.pause = 1'b0;
      chk("abort over pause", 32'(sample() >> 4), 32'(mk(8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0) >> 4));

      // reset in DOWN with start held
      sw_if.lo     = 8'd0;
      sw_if.hi     = 8'd5;
      sw_if.cycles = 4'd1;
      sw_if.start  = 1'b1;
      @(negedge clk);
      sw_if.start = 1'b0;
      wait_for(8'd3, 1'b0, 20, "reach 3 down");
      rst         = 1'b0;
      sw_if.start = 1'b1;
      @(negedge clk);
      chk("reset mid sweep", 32'(sample()), 32'(mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0)));
      @(negedge clk);
      chk("start ignored in reset", 32'(sample()), 32'(mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0)));
      rst         = 1'b1;
      sw_if.start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("no done after reset", 32'(sample()), 32'(mk(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
